// File: rtl/alu_nibble_seq.sv
// Nibble-serial 16-bit ALU: one 4-bit slice iterated over four EXEC cycles, result valid 4 edges after accept.
// Backpressure: result held in DONE until out_ready; no new request accepted until back in IDLE.
module alu_nibble_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic        cin,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        cout,
    output logic        zero,
    output logic        busy
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  cnt;
    logic [1:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        carry;
    logic        accept;
    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [3:0]  nib_b_eff;
    logic [3:0]  nib_r;
    logic [4:0]  sum;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = EXEC;
            EXEC:    if (cnt == 2'd3) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Single 4-bit slice; subtraction is add-with-inverted-b and carry seeded to 1.
    always_comb begin
        nib_a     = a_q[{cnt, 2'b00} +: 4];
        nib_b     = b_q[{cnt, 2'b00} +: 4];
        nib_b_eff = (op_q == OP_SUB) ? ~nib_b : nib_b;
        sum       = {1'b0, nib_a} + {1'b0, nib_b_eff} + {4'b0000, carry};
        case (op_q)
            OP_AND:  nib_r = nib_a & nib_b;
            OP_XOR:  nib_r = nib_a ^ nib_b;
            default: nib_r = sum[3:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= 2'd0;
            op_q   <= OP_ADD;
            a_q    <= 16'h0000;
            b_q    <= 16'h0000;
            carry  <= 1'b0;
            result <= 16'h0000;
            cout   <= 1'b0;
            zero   <= 1'b1;
        end else if (accept) begin
            cnt   <= 2'd0;
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            carry <= (op == OP_SUB) || ((op == OP_ADD) && cin);
        end else if (state == EXEC) begin
            result[{cnt, 2'b00} +: 4] <= nib_r;
            carry                     <= sum[4];
            cnt                       <= cnt + 2'd1;
            if (cnt == 2'd3) begin
                cout <= sum[4] & ~op_q[1];
                zero <= ({nib_r, result[11:0]} == 16'h0000);
            end
        end
    end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Scoreboarded bench for alu_nibble_seq: directed vectors, backpressure and mid-operation reset.
module tb_alu_nibble_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        cout;
    logic        zero;
    logic        busy;

    alu_nibble_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .cin       (cin),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .zero      (zero),
        .busy      (busy)
    );

    typedef struct {
        logic [15:0] res;
        logic        co;
        logic        z;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   shown  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: compares every cycle the DUT presents a result, pops on hand-off.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                e = sb[0];
                if (!shown) begin
                    chk("latency", cyc - e.acc, 4);
                    shown = 1;
                end
                chk("result", int'(result), int'(e.res));
                chk("cout", int'(cout), int'(e.co));
                chk("zero", int'(zero), int'(e.z));
                chk("in_ready_in_done", int'(in_ready), 0);
                if (out_ready) begin
                    void'(sb.pop_front());
                    shown = 0;
                end
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic c, input logic [15:0] x,
                         input logic [15:0] y, input logic [15:0] er, input logic ec,
                         input logic ez, input bit push);
        int n = 0;
        @(negedge clk);
        op = o; cin = c; a = x; b = y; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (push) sb.push_back('{er, ec, ez, cyc});
            // Scramble inputs so any late sampling of them corrupts the result.
            op  = 2'($urandom);
            cin = 1'($urandom);
            a   = 16'($urandom);
            b   = 16'($urandom);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    localparam int NV = 8;
    logic [1:0]  v_op  [NV] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    logic        v_cin [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] v_a   [NV] = '{16'h1234, 16'hFFFF, 16'h0005, 16'h8000, 16'hF0F0, 16'hAAAA, 16'h00FF, 16'h0010};
    logic [15:0] v_b   [NV] = '{16'h0FCD, 16'h0001, 16'h0007, 16'h8000, 16'hFF00, 16'hAAAA, 16'h0000, 16'h0001};
    logic [15:0] v_res [NV] = '{16'h2201, 16'h0000, 16'hFFFE, 16'h0000, 16'hF000, 16'h0000, 16'h0100, 16'h000F};
    logic        v_co  [NV] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        v_z   [NV] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = 2'b00; cin = 1'b0; a = 16'h0000; b = 16'h0000;
        #1;
        chk("rst_result", int'(result), 0);
        chk("rst_cout", int'(cout), 0);
        chk("rst_zero", int'(zero), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", int'(in_ready), 1);

        for (int i = 0; i < NV; i++) begin
            issue(v_op[i], v_cin[i], v_a[i], v_b[i], v_res[i], v_co[i], v_z[i], 1'b1);
            wait_drain();
        end

        // Backpressure: hold result 10 cycles while another request waits.
        out_ready = 1'b0;
        issue(2'b00, 1'b0, 16'h0F0F, 16'h00F1, 16'h1000, 1'b0, 1'b0, 1'b1);
        op = 2'b11; cin = 1'b0; a = 16'h1234; b = 16'hFFFF; in_valid = 1'b1;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", int'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid_hold", int'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle_in_ready", int'(in_ready), 1);
        chk("bp_idle_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("bp_next_accept", int'(busy), 1);
        sb.push_back('{16'hEDCB, 1'b0, 1'b0, cyc});
        in_valid = 1'b0;
        wait_drain();

        // Reset asynchronously between edges after nibble 1 of an ADD.
        issue(2'b00, 1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_result", int'(result), 0);
        chk("arst_cout", int'(cout), 0);
        chk("arst_zero", int'(zero), 1);
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_busy", int'(busy), 0);
        #4;
        rst = 1'b0;
        op = 2'b00; cin = 1'b0; a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("first_edge_accept", int'(busy), 1);
        sb.push_back('{16'h0002, 1'b0, 1'b0, cyc});
        in_valid = 1'b0;
        wait_drain();

        repeat (10) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
